// File: rtl/stereo_frame_assembler_pkg.sv
// Shared definitions for the stereo frame assembler: sample width and pairing FSM states.
`default_nettype none

package stereo_frame_assembler_pkg;

  localparam int SAMPLE_W = 32;
  localparam int FRAME_W  = 2 * SAMPLE_W;

  typedef enum logic {
    ST_WAIT_LEFT  = 1'b0,
    ST_WAIT_RIGHT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/audio_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is taken only when a pop frees a slot that cycle.
`default_nettype none

module audio_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     sclk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             wr_en;
  logic             rd_en;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/stereo_frame_assembler.sv
// Pairs left/right decoder samples into stereo frames and queues them; drops instead of stalling.
`default_nettype none

module stereo_frame_assembler
  import stereo_frame_assembler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     sclk,
  input  logic                     reset_n,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic                     i_is_left,
  input  logic [SAMPLE_W-1:0]      i_audio,
  input  logic                     i_error,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [SAMPLE_W-1:0]      o_left,
  output logic [SAMPLE_W-1:0]      o_right,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  input  logic                     clear_status
);

  localparam int SUM_W = CNT_W + 1;

  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] held_q, held_d;
  logic                ready_q;
  logic                overflow_q;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic [1:0]          drop_inc;
  logic [SUM_W-1:0]    drop_sum;
  logic                set_ovf;
  logic                push;
  logic                pop;
  logic                accept;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FRAME_W-1:0]  head;

  assign accept  = i_valid & ready_q;
  assign o_valid = ~fifo_empty;
  assign pop     = o_valid & o_ready;

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    drop_inc = 2'd0;
    push     = 1'b0;
    set_ovf  = 1'b0;
    if (i_error) begin
      state_d  = ST_WAIT_LEFT;
      held_d   = '0;
      drop_inc = 2'(state_q == ST_WAIT_RIGHT) + 2'(accept);
    end else if (accept) begin
      case (state_q)
        ST_WAIT_LEFT: begin
          if (i_is_left) begin
            held_d  = i_audio;
            state_d = ST_WAIT_RIGHT;
          end else begin
            drop_inc = 2'd1;
          end
        end
        ST_WAIT_RIGHT: begin
          if (i_is_left) begin
            held_d   = i_audio;
            drop_inc = 2'd1;
          end else begin
            state_d = ST_WAIT_LEFT;
            // A pop in the same cycle frees the slot, so full alone is not an overflow.
            if (fifo_full && !pop) begin
              drop_inc = 2'd1;
              set_ovf  = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
        end
        default: state_d = ST_WAIT_LEFT;
      endcase
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_q} + SUM_W'(drop_inc);
    drop_d   = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_WAIT_LEFT;
      held_q     <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      ready_q <= 1'b1;
      if (clear_status) begin
        overflow_q <= 1'b0;
        drop_q     <= '0;
      end else begin
        overflow_q <= overflow_q | set_ovf;
        drop_q     <= drop_d;
      end
    end
  end

  audio_sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sclk    (sclk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  ({held_q, i_audio}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign i_ready    = ready_q;
  assign o_left     = head[FRAME_W-1:SAMPLE_W];
  assign o_right    = head[SAMPLE_W-1:0];
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_stereo_frame_assembler.sv
// Directed bench for stereo_frame_assembler with hand-computed expectations.
`default_nettype none

module tb_stereo_frame_assembler;

  logic        sclk = 1'b0;
  logic        reset_n;
  logic        i_valid;
  logic        i_ready;
  logic        i_is_left;
  logic [31:0] i_audio;
  logic        i_error;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_left;
  logic [31:0] o_right;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        clear_status;

  int checks = 0;
  int errors = 0;

  stereo_frame_assembler #(.DEPTH(4), .CNT_W(8)) dut (
    .sclk         (sclk),
    .reset_n      (reset_n),
    .i_valid      (i_valid),
    .i_ready      (i_ready),
    .i_is_left    (i_is_left),
    .i_audio      (i_audio),
    .i_error      (i_error),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_left       (o_left),
    .o_right      (o_right),
    .level        (level),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clear_status (clear_status)
  );

  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic send(input logic left, input logic [31:0] d);
    i_valid   = 1'b1;
    i_is_left = left;
    i_audio   = d;
    tick();
    i_valid   = 1'b0;
    i_is_left = 1'b0;
    i_audio   = '0;
  endtask

  task automatic clr;
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; i_valid = 0; i_is_left = 0; i_audio = 0; i_error = 0;
    o_ready = 0; clear_status = 0;
    #2;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready: got %b expected 0", i_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL reset_status: got ovf=%b drop=%0d expected 0/0", overflow, drop_count); end
    checks++; if (o_left !== 32'd0 || o_right !== 32'd0) begin errors++; $display("FAIL reset_head: got %h/%h expected 0/0", o_left, o_right); end
    tick();
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_hold_ready: got %b expected 0", i_ready); end
    reset_n = 1'b1;
    tick();
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", i_ready); end
  endtask

  task automatic test_basic;
    o_ready = 1'b1;
    send(1'b1, 32'h12345600);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_no_early: got %b expected 0", o_valid); end
    send(1'b0, 32'hABCDEF00);
    checks++; if (o_valid !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL basic_valid: got v=%b lvl=%0d expected 1/1", o_valid, level); end
    checks++; if (o_left !== 32'h12345600 || o_right !== 32'hABCDEF00) begin errors++; $display("FAIL basic_frame: got %h/%h expected 12345600/abcdef00", o_left, o_right); end
    tick();
    checks++; if (o_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL basic_one_cycle: got v=%b lvl=%0d expected 0/0", o_valid, level); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL basic_drop: got %0d expected 0", drop_count); end
  endtask

  task automatic test_orphans;
    o_ready = 1'b0;
    send(1'b0, 32'h0000_00AA);
    send(1'b1, 32'h1111_1100);
    send(1'b1, 32'h2222_2200);
    send(1'b0, 32'h3333_3300);
    checks++; if (o_valid !== 1'b1 || o_left !== 32'h2222_2200 || o_right !== 32'h3333_3300) begin errors++; $display("FAIL orphan_frame: got v=%b %h/%h expected 1 22222200/33333300", o_valid, o_left, o_right); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL orphan_drop: got %0d expected 2", drop_count); end
    o_ready = 1'b1; tick(); o_ready = 1'b0;
    clr();
  endtask

  task automatic test_error;
    send(1'b1, 32'h4444_4400);
    i_error = 1'b1; tick(); i_error = 1'b0;
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL error_held_drop: got %0d expected 1", drop_count); end
    i_error = 1'b1; tick(); tick(); i_error = 1'b0;
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL error_hold_nocount: got %0d expected 1", drop_count); end
    send(1'b0, 32'h5555_5500);
    checks++; if (o_valid !== 1'b0 || drop_count !== 8'd2) begin errors++; $display("FAIL error_no_frame: got v=%b drop=%0d expected 0/2", o_valid, drop_count); end
    send(1'b1, 32'h6666_6600);
    send(1'b0, 32'h7777_7700);
    checks++; if (level !== 3'd1 || o_left !== 32'h6666_6600 || o_right !== 32'h7777_7700) begin errors++; $display("FAIL error_recover: got lvl=%0d %h/%h expected 1 66666600/77777700", level, o_left, o_right); end
    // Error while a sample is offered in WAIT_RIGHT: held and new sample both drop.
    send(1'b1, 32'h8888_8800);
    i_error = 1'b1; send(1'b0, 32'h9999_9900); i_error = 1'b0;
    checks++; if (drop_count !== 8'd4 || level !== 3'd1) begin errors++; $display("FAIL error_double: got drop=%0d lvl=%0d expected 4/1", drop_count, level); end
    o_ready = 1'b1; tick(); o_ready = 1'b0;
    clr();
  endtask

  task automatic test_overflow;
    o_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send(1'b1, 32'h1000_0000 + k);
      send(1'b0, 32'h2000_0000 + k);
    end
    checks++; if (level !== 3'd4 || overflow !== 1'b1 || drop_count !== 8'd2) begin errors++; $display("FAIL ovf_status: got lvl=%0d ovf=%b drop=%0d expected 4/1/2", level, overflow, drop_count); end
    o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_valid !== 1'b1 || o_left !== 32'h1000_0000 + k || o_right !== 32'h2000_0000 + k) begin errors++; $display("FAIL ovf_drain_%0d: got v=%b %h/%h expected 1 %h/%h", k, o_valid, o_left, o_right, 32'h1000_0000 + k, 32'h2000_0000 + k); end
      tick();
    end
    checks++; if (o_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL ovf_empty: got v=%b lvl=%0d expected 0/0", o_valid, level); end
    o_ready = 1'b0;
    clr();
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 32'hA000_0000 + k);
      send(1'b0, 32'hB000_0000 + k);
    end
    send(1'b1, 32'hA000_0004);
    o_ready = 1'b1;
    send(1'b0, 32'hB000_0004);
    o_ready = 1'b0;
    checks++; if (level !== 3'd4 || overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL full_pushpop: got lvl=%0d ovf=%b drop=%0d expected 4/0/0", level, overflow, drop_count); end
    checks++; if (o_left !== 32'hA000_0001 || o_right !== 32'hB000_0001) begin errors++; $display("FAIL full_hold_head: got %h/%h expected a0000001/b0000001", o_left, o_right); end
    tick();
    checks++; if (o_left !== 32'hA000_0001 || level !== 3'd4) begin errors++; $display("FAIL full_stable: got %h lvl=%0d expected a0000001/4", o_left, level); end
    o_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      checks++; if (o_valid !== 1'b1 || o_left !== 32'hA000_0000 + k || o_right !== 32'hB000_0000 + k) begin errors++; $display("FAIL full_order_%0d: got v=%b %h/%h expected 1 %h/%h", k, o_valid, o_left, o_right, 32'hA000_0000 + k, 32'hB000_0000 + k); end
      tick();
    end
    o_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(1'b1, 32'hC000_0000 + k);
      send(1'b0, 32'hD000_0000 + k);
    end
    checks++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL clr_pre: got ovf=%b drop=%0d expected 1/1", overflow, drop_count); end
    // Orphan right offered in the same cycle as the clear: the clear wins.
    clear_status = 1'b1; send(1'b0, 32'hEEEE_EE00); clear_status = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL clr_wins: got ovf=%b drop=%0d expected 0/0", overflow, drop_count); end
    o_ready = 1'b1;
    repeat (4) tick();
    o_ready = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL clr_drain: got %b expected 0", o_valid); end
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 260; k++) begin
      send(1'b0, k);
    end
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d expected 255", drop_count); end
    clr();
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL drop_clear: got %0d expected 0", drop_count); end
  endtask

  task automatic test_reset_mid;
    o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(1'b1, 32'hF000_0000 + k);
      send(1'b0, 32'hE000_0000 + k);
    end
    send(1'b1, 32'h0BAD_0000);
    send(1'b0, 32'h0000_0001);
    send(1'b1, 32'h0BAD_0001);
    checks++; if (level !== 3'd4 - 3'd0 - 3'd0 && level !== 3'd4) begin errors++; $display("FAIL midrst_pre: got %0d expected 4", level); end
    o_ready = 1'b1; tick(); o_ready = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL midrst_level3: got %0d expected 3", level); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (i_ready !== 1'b0 || o_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL midrst_async: got rdy=%b v=%b lvl=%0d expected 0/0/0", i_ready, o_valid, level); end
    checks++; if (o_left !== 32'd0 || o_right !== 32'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL midrst_outputs: got %h/%h ovf=%b drop=%0d expected zeros", o_left, o_right, overflow, drop_count); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", i_ready); end
    // A right here would be an orphan if the old held left had survived.
    send(1'b1, 32'h1357_9B00);
    send(1'b0, 32'h2468_AC00);
    checks++; if (level !== 3'd1 || o_left !== 32'h1357_9B00 || o_right !== 32'h2468_AC00 || drop_count !== 8'd0) begin errors++; $display("FAIL midrst_frame: got lvl=%0d %h/%h drop=%0d expected 1 13579b00/2468ac00 0", level, o_left, o_right, drop_count); end
    o_ready = 1'b1; tick(); o_ready = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_single: got %b expected 0", o_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_orphans();
    test_error();
    test_overflow();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
